// File: rtl/simmem_bank_timing.sv
// -----------------------------------------------------------------------------
// simmem_bank_timing
//   Multi-bank DRAM row-buffer timing model for the simmem delay path. Each bank
//   holds at most one request and remembers its open row. An accepted request
//   costs RowHitCost (row hit), ActivationCost+RowHitCost (bank closed) or
//   PrechargeCost+ActivationCost+RowHitCost (row miss). The bank counts that
//   cost down, then offers the request's iid on the response port. A
//   round-robin arbiter picks among the finished banks.
//
// Configuration macro:
//   SIMMEM_BANK_CLOSE_PAGE_EN  defined   -> close-page policy. The row is closed
//                                           on the response handshake, so every
//                                           access is a closed-bank access and
//                                           rsp_row_hit_o is always 0.
//                              undefined -> open-page policy. The row stays open
//                                           after the access.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-high reset
//   req_valid_i    request valid
//   req_ready_o    target bank is idle; the request is accepted on valid & ready
//   req_addr_i     byte address, decoded as row | bank | column
//   req_iid_i      internal id of the request
//   rsp_valid_o    a completion is offered
//   rsp_ready_i    the completion is consumed on valid & ready
//   rsp_iid_o      iid of the offered completion (0 when none)
//   rsp_row_hit_o  the offered completion was a row hit (0 when none)
//   bank_busy_o    per-bank occupancy (counting or waiting to respond)
// -----------------------------------------------------------------------------
module simmem_bank_timing #(
   parameter int NumBanks          = 4,
   parameter int AddrWidth         = 16,
   parameter int RowBufferLenWidth = 8,
   parameter int IidWidth          = 5,
   parameter int RowHitCost        = 4,
   parameter int PrechargeCost     = 2,
   parameter int ActivationCost    = 1,
   parameter int DelayWidth        = 6
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                req_valid_i,
   output logic                req_ready_o,
   input  logic [AddrWidth-1:0] req_addr_i,
   input  logic [IidWidth-1:0]  req_iid_i,
   output logic                rsp_valid_o,
   input  logic                rsp_ready_i,
   output logic [IidWidth-1:0]  rsp_iid_o,
   output logic                rsp_row_hit_o,
   output logic [NumBanks-1:0]  bank_busy_o
);

   localparam int BankW = $clog2(NumBanks);
   localparam int RowW  = AddrWidth - RowBufferLenWidth - BankW;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StCount = 2'd1;
   localparam logic [1:0] StDone  = 2'd2;

   localparam logic [DelayWidth-1:0] CostHit    = DelayWidth'(RowHitCost);
   localparam logic [DelayWidth-1:0] CostClosed = DelayWidth'(ActivationCost + RowHitCost);
   localparam logic [DelayWidth-1:0] CostMiss   = DelayWidth'(PrechargeCost + ActivationCost + RowHitCost);

   if (PrechargeCost + ActivationCost + RowHitCost >= 2**DelayWidth) begin : g_bad_delay_width
      $error("simmem_bank_timing: worst-case cost does not fit in DelayWidth");
   end
   if (RowHitCost < 3) begin : g_bad_row_hit_cost
      $error("simmem_bank_timing: RowHitCost must be >= 3");
   end
   if (NumBanks < 2 || (NumBanks & (NumBanks - 1)) != 0) begin : g_bad_num_banks
      $error("simmem_bank_timing: NumBanks must be a power of two >= 2");
   end

   // Address decode.
   logic [BankW-1:0] req_bank;
   logic [RowW-1:0]  req_row;
   logic             unused_col_bits;

   assign req_bank        = req_addr_i[RowBufferLenWidth +: BankW];
   assign req_row         = req_addr_i[AddrWidth-1 -: RowW];
   assign unused_col_bits = ^req_addr_i[RowBufferLenWidth-1:0];

   // Per-bank state.
   logic [1:0]            state_q    [NumBanks];
   logic [DelayWidth-1:0] count_q    [NumBanks];
   logic [RowW-1:0]       open_row_q [NumBanks];
   logic [IidWidth-1:0]   iid_q      [NumBanks];
   logic [NumBanks-1:0]   row_valid_q;
   logic [NumBanks-1:0]   hit_q;

   // Response arbitration state.
   logic [BankW-1:0] rr_ptr_q;
   logic             hold_q;
   logic [BankW-1:0] hold_idx_q;

   logic                  req_fire;
   logic                  req_hit;
   logic [DelayWidth-1:0] req_cost;
   logic                  any_done;
   logic [BankW-1:0]      rr_pick;
   logic [BankW-1:0]      rsp_sel;
   logic                  rsp_fire;

   // Readiness looks only at registered bank state, never at rsp_ready_i.
   assign req_ready_o = (state_q[req_bank] == StIdle);
   assign req_fire    = req_valid_i & req_ready_o;

`ifdef SIMMEM_BANK_CLOSE_PAGE_EN
   assign req_hit = 1'b0;
`else
   assign req_hit = row_valid_q[req_bank] && (open_row_q[req_bank] == req_row);
`endif

   assign req_cost = req_hit                ? CostHit  :
                     row_valid_q[req_bank]  ? CostMiss : CostClosed;

   // Round-robin search from rr_ptr_q; the bank index wraps naturally because
   // NumBanks is a power of two.
   always_comb begin
      // NOTE: every variable written in always_comb gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      any_done = 1'b0;
      rr_pick  = rr_ptr_q;
      for (int i = 0; i < NumBanks; i++) begin
         if (!any_done && state_q[rr_ptr_q + BankW'(i)] == StDone) begin
            any_done = 1'b1;
            rr_pick  = rr_ptr_q + BankW'(i);
         end
      end
   end

   // A completion offered but not yet taken stays selected, even if a bank
   // earlier in round-robin order finishes in the meantime.
   assign rsp_sel       = hold_q ? hold_idx_q : rr_pick;
   assign rsp_valid_o   = any_done;
   assign rsp_fire      = rsp_valid_o & rsp_ready_i;
   assign rsp_iid_o     = rsp_valid_o ? iid_q[rsp_sel] : '0;
   assign rsp_row_hit_o = rsp_valid_o & hit_q[rsp_sel];

   always_comb begin
      bank_busy_o = '0;
      for (int b = 0; b < NumBanks; b++) begin
         bank_busy_o[b] = (state_q[b] != StIdle);
      end
   end

   // Control state: bank FSMs, open-row validity and the arbiter.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int b = 0; b < NumBanks; b++) begin
            state_q[b] <= StIdle;
         end
         row_valid_q <= '0;
         rr_ptr_q    <= '0;
         hold_q      <= 1'b0;
         hold_idx_q  <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every bank
         // sees the pre-edge values of all the others.
         for (int b = 0; b < NumBanks; b++) begin
            case (state_q[b])
               StIdle:  if (req_fire && req_bank == BankW'(b)) state_q[b] <= StCount;
               // Leaving on 1 (not 0) puts the bank in DONE exactly cost
               // cycles after the accept, since the load value is cost-1.
               StCount: if (count_q[b] == DelayWidth'(1)) state_q[b] <= StDone;
               StDone:  if (rsp_fire && rsp_sel == BankW'(b)) state_q[b] <= StIdle;
               default: state_q[b] <= StIdle;
            endcase

            if (req_fire && req_bank == BankW'(b)) begin
               row_valid_q[b] <= 1'b1;
`ifdef SIMMEM_BANK_CLOSE_PAGE_EN
            end else if (rsp_fire && rsp_sel == BankW'(b)) begin
               row_valid_q[b] <= 1'b0;
`endif
            end
         end

         if (rsp_fire) begin
            rr_ptr_q <= rsp_sel + BankW'(1);
         end
         hold_q     <= rsp_valid_o & ~rsp_ready_i;
         hold_idx_q <= rsp_sel;
      end
   end

   // Per-bank payload and counter.
   // NOTE: these registers are deliberately not reset; they are only read while
   // the bank FSM (which is reset) says they hold a live request or open row.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < NumBanks; b++) begin
         if (req_fire && req_bank == BankW'(b)) begin
            count_q[b]    <= req_cost - DelayWidth'(1);
            open_row_q[b] <= req_row;
            iid_q[b]      <= req_iid_i;
            hit_q[b]      <= req_hit;
         end else if (state_q[b] == StCount) begin
            count_q[b] <= count_q[b] - DelayWidth'(1);
         end
      end
   end

endmodule

// File: tb/tb_simmem_bank_timing.sv
// Self-checking bench for simmem_bank_timing (default parameters).
module tb_simmem_bank_timing;

   localparam int NB  = 4;
   localparam int AW  = 16;
   localparam int RBW = 8;
   localparam int IW  = 5;
   localparam int HIT = 4;
   localparam int PRE = 2;
   localparam int ACT = 1;
   localparam int DW  = 6;
`ifdef SIMMEM_BANK_CLOSE_PAGE_EN
   localparam bit CLOSE = 1'b1;
`else
   localparam bit CLOSE = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_i = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic [AW-1:0] req_addr = '0;
   logic [IW-1:0] req_iid = '0;
   logic          rsp_valid;
   logic          rsp_ready = 1'b1;
   logic [IW-1:0] rsp_iid;
   logic          rsp_row_hit;
   logic [NB-1:0] bank_busy;

   int total = 0;
   int bad   = 0;

   simmem_bank_timing #(
      .NumBanks(NB), .AddrWidth(AW), .RowBufferLenWidth(RBW), .IidWidth(IW),
      .RowHitCost(HIT), .PrechargeCost(PRE), .ActivationCost(ACT), .DelayWidth(DW)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst_i),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_addr_i   (req_addr),
      .req_iid_i    (req_iid),
      .rsp_valid_o  (rsp_valid),
      .rsp_ready_i  (rsp_ready),
      .rsp_iid_o    (rsp_iid),
      .rsp_row_hit_o(rsp_row_hit),
      .bank_busy_o  (bank_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Behavioural model: each bank is "busy until cycle done_at", then offers its
   // completion. Cycle numbers are counted at the rising edge.
   // ---------------------------------------------------------------------------
   int cyc = 0;
   bit m_busy [NB];
   int m_done_at [NB];
   int m_iid [NB];
   bit m_hit [NB];
   int m_row [NB];
   bit m_rv [NB];
   int m_ptr = 0;
   bit m_hold = 1'b0;
   int m_hold_idx = 0;

   function automatic int bank_of(input logic [AW-1:0] a);
      return int'((a >> RBW) % NB);
   endfunction

   function automatic int row_of(input logic [AW-1:0] a);
      return int'(a >> (RBW + $clog2(NB)));
   endfunction

   function automatic int exp_sel();
      if (m_hold) return m_hold_idx;
      for (int i = 0; i < NB; i++) begin
         if (m_busy[(m_ptr + i) % NB] && cyc >= m_done_at[(m_ptr + i) % NB])
            return (m_ptr + i) % NB;
      end
      return -1;
   endfunction

   always @(posedge clk or posedge rst_i) begin : model
      int s;
      int b;
      bit acc;
      bit hit;
      int cost;
      if (rst_i) begin
         for (int k = 0; k < NB; k++) begin
            m_busy[k] = 1'b0;
            m_rv[k]   = 1'b0;
         end
         m_ptr  = 0;
         m_hold = 1'b0;
      end else begin
         s   = exp_sel();
         b   = bank_of(req_addr);
         acc = req_valid && !m_busy[b];
         if (s >= 0 && rsp_ready) begin
            m_busy[s] = 1'b0;
            m_ptr     = (s + 1) % NB;
            if (CLOSE) m_rv[s] = 1'b0;
         end
         m_hold     = (s >= 0) && !rsp_ready;
         m_hold_idx = s;
         if (acc) begin
            hit  = !CLOSE && m_rv[b] && (m_row[b] == row_of(req_addr));
            cost = hit ? HIT : (m_rv[b] ? PRE + ACT + HIT : ACT + HIT);
            m_busy[b]    = 1'b1;
            m_done_at[b] = cyc + cost;
            m_iid[b]     = int'(req_iid);
            m_hit[b]     = hit;
            m_row[b]     = row_of(req_addr);
            m_rv[b]      = 1'b1;
         end
         cyc++;
      end
   end

   // One compare process: outputs against the model on every falling edge.
   always @(negedge clk) begin : compare
      int s;
      logic [NB-1:0] eb;
      if (!rst_i) begin
         for (int k = 0; k < NB; k++) eb[k] = m_busy[k];
         s = exp_sel();
         check("mdl_ready", {31'b0, req_ready}, {31'b0, !m_busy[bank_of(req_addr)]});
         check("mdl_busy", {28'b0, bank_busy}, {28'b0, eb});
         check("mdl_rsp_valid", {31'b0, rsp_valid}, {31'b0, s >= 0});
         if (s >= 0) begin
            check("mdl_rsp_iid", {27'b0, rsp_iid}, m_iid[s]);
            check("mdl_rsp_hit", {31'b0, rsp_row_hit}, {31'b0, m_hit[s]});
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus. Tasks start and end 2 time units after a rising edge.
   // ---------------------------------------------------------------------------
   task automatic send(input logic [AW-1:0] a, input logic [IW-1:0] id, output int t_acc);
      bit ok;
      ok        = 1'b0;
      t_acc     = -1;
      req_valid = 1'b1;
      req_addr  = a;
      req_iid   = id;
      for (int k = 0; k < 40 && !ok; k++) begin
         @(negedge clk);
         if (req_ready) begin
            ok    = 1'b1;
            t_acc = cyc;
         end
         @(posedge clk);
         #2;
      end
      req_valid = 1'b0;
      if (!ok) check("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic wait_rsp(input string nm, input int eiid, input bit ehit,
                           input int t_acc, input int ecost);
      bit got;
      got = 1'b0;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (rsp_valid && rsp_ready) begin
            got = 1'b1;
            check({nm, "_iid"}, {27'b0, rsp_iid}, eiid);
            check({nm, "_hit"}, {31'b0, rsp_row_hit}, {31'b0, ehit});
            check({nm, "_latency"}, cyc - t_acc, ecost);
         end
      end
      if (!got) check({nm, "_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #2;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int t0;
      int t1;
      repeat (3) @(posedge clk);
      #2 rst_i = 1'b0;

      // Reset state.
      #1;
      check("rst_ready_0000", {31'b0, req_ready}, 32'd1);
      req_addr = 16'h0300;
      #1;
      check("rst_ready_0300", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_rsp_iid", {27'b0, rsp_iid}, 32'd0);
      check("rst_rsp_hit", {31'b0, rsp_row_hit}, 32'd0);
      check("rst_busy", {28'b0, bank_busy}, 32'd0);
      req_addr = '0;
      @(posedge clk);
      #2;

      // Cold bank, row hit, row miss on bank 0.
      send(16'h0000, 5'd3, t0);
      wait_rsp("cold", 3, 1'b0, t0, 5);
      send(16'h0010, 5'd4, t0);
      wait_rsp("hit", 4, !CLOSE, t0, CLOSE ? 5 : 4);
      send(16'h0400, 5'd5, t0);
      wait_rsp("miss", 5, 1'b0, t0, CLOSE ? 5 : 7);

      // Overlap and fairness: fresh reset so the pointer starts at bank 0.
      rst_i = 1'b1;
      @(posedge clk);
      #2 rst_i = 1'b0;
      rsp_ready = 1'b0;
      send(16'h0000, 5'd6, t0);
      send(16'h0100, 5'd7, t1);
      check("ovl_consecutive", t1 - t0, 32'd1);
      repeat (8) @(posedge clk);
      #2;
      @(negedge clk);
      check("ovl_valid_held", {31'b0, rsp_valid}, 32'd1);
      check("ovl_iid_held", {27'b0, rsp_iid}, 32'd6);
      check("ovl_busy", {28'b0, bank_busy}, 32'h3);
      @(posedge clk);
      #2 rsp_ready = 1'b1;
      @(negedge clk);
      check("ovl_first", {27'b0, rsp_iid}, 32'd6);
      @(negedge clk);
      check("ovl_second", {27'b0, rsp_iid}, 32'd7);
      @(negedge clk);
      check("ovl_drained", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #2;

      // Backpressure on bank 0 (pointer now at 2); bank 3 finishes later but
      // earlier in round-robin order, and must not displace the held response.
      rsp_ready = 1'b0;
      send(16'h0000, 5'd8, t0);
      repeat (5) @(posedge clk);
      #2;
      send(16'h0300, 5'd9, t1);
      req_addr = 16'h0020;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_iid", {27'b0, rsp_iid}, 32'd8);
         check("bp_busy0", {31'b0, bank_busy[0]}, 32'd1);
         check("bp_ready_0020", {31'b0, req_ready}, 32'd0);
      end
      @(posedge clk);
      #2 rsp_ready = 1'b1;
      @(negedge clk);
      check("bp_release_iid", {27'b0, rsp_iid}, 32'd8);
      @(negedge clk);
      check("bp_next_iid", {27'b0, rsp_iid}, 32'd9);
      @(negedge clk);
      check("bp_drained", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #2;

      // Mid-operation reset while bank 2 is counting.
      send(16'h0200, 5'd10, t0);
      repeat (2) @(posedge clk);
      #2 rst_i = 1'b1;
      #2 rst_i = 1'b0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         check("mr_no_rsp", {31'b0, rsp_valid}, 32'd0);
      end
      @(posedge clk);
      #2;
      send(16'h0200, 5'd11, t0);
      wait_rsp("mr_cold", 11, 1'b0, t0, 5);

      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
